// File: rtl/rename_pkg.sv
// Shared rename-stage parameters and types for the physical-register free list.
package rename_pkg;

    localparam int PRF_WIDTH = 6;
    localparam int ARCH_NUM  = 32;
    localparam int PRF_NUM   = 64;
    localparam int WIDTH     = 4;
    localparam int FL_DEPTH  = PRF_NUM - ARCH_NUM;
    localparam int FL_PTR_W  = $clog2(FL_DEPTH) + 1;

    typedef logic [PRF_WIDTH-1:0] prf_tag_t;
    typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/slot_prefix4.sv
// Turns a 4-slot valid mask into its popcount and each slot's count of set slots below it.
module slot_prefix4 (
    input  logic [3:0] mask,
    output logic [2:0] count,
    output logic [7:0] prefix
);

    always_comb begin
        prefix[1:0] = 2'd0;
        prefix[3:2] = 2'(mask[0]);
        prefix[5:4] = 2'(mask[0]) + 2'(mask[1]);
        prefix[7:6] = 2'(mask[0]) + 2'(mask[1]) + 2'(mask[2]);
        count       = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags: rename pops from the speculative head, commit pushes
// retired tags at the tail, and flush rewinds the speculative head to the committed head.
module free_list
    import rename_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           alloc_valid,
    output logic                       alloc_ready,
    output logic [WIDTH*PRF_WIDTH-1:0] alloc_prd,
    input  logic [WIDTH-1:0]           rel_valid,
    input  logic [WIDTH*PRF_WIDTH-1:0] rel_preprd,
    input  logic                       flush,
    output logic [PRF_WIDTH-1:0]       free_count
);

    prf_tag_t fifo [FL_DEPTH];
    fl_ptr_t  head, arch_head, tail, count;
    fl_ptr_t  rd_ptr [WIDTH];
    fl_ptr_t  wr_ptr [WIDTH];
    logic [2:0] n_a, n_r;
    logic [7:0] pa, pr;
    logic       alloc_fire;

    slot_prefix4 u_alloc_prefix (.mask(alloc_valid), .count(n_a), .prefix(pa));
    slot_prefix4 u_rel_prefix   (.mask(rel_valid),   .count(n_r), .prefix(pr));

    // The wrap bit keeps a full list (32) distinct from an empty one (0).
    assign count       = tail - head;
    assign free_count  = count;
    assign alloc_ready = count >= fl_ptr_t'(n_a);
    assign alloc_fire  = alloc_ready & (|alloc_valid) & ~flush;

    always_comb begin
        alloc_prd = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rd_ptr[k] = head + fl_ptr_t'(pa[2*k +: 2]);
            wr_ptr[k] = tail + fl_ptr_t'(pr[2*k +: 2]);
            alloc_prd[k*PRF_WIDTH +: PRF_WIDTH] = fifo[rd_ptr[k][FL_PTR_W-2:0]];
        end
    end

    // Every committing writer consumed one tag at rename, so the committed head trails commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            arch_head <= '0;
            tail      <= fl_ptr_t'(FL_DEPTH);
        end else begin
            tail      <= tail + fl_ptr_t'(n_r);
            arch_head <= arch_head + fl_ptr_t'(n_r);
            if (flush)
                head <= arch_head + fl_ptr_t'(n_r);
            else if (alloc_fire)
                head <= head + fl_ptr_t'(n_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                fifo[i] <= prf_tag_t'(ARCH_NUM + i);
        end else begin
            for (int k = 0; k < WIDTH; k++)
                if (rel_valid[k])
                    fifo[wr_ptr[k][FL_PTR_W-2:0]] <= rel_preprd[k*PRF_WIDTH +: PRF_WIDTH];
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        (32'(count) + 32'(n_r)) <= FL_DEPTH);

    for (genvar k = 0; k < WIDTH; k++) begin : g_chk
        no_zero_tag: assert property (@(posedge clk) disable iff (rst)
            !(rel_valid[k] && rel_preprd[k*PRF_WIDTH +: PRF_WIDTH] == '0));
    end

endmodule

// File: tb/tb_free_list.sv
// Directed vectors plus multi-cycle corner sequences and a queue-model random run for free_list.
module tb_free_list;
    import rename_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alloc_valid;
    logic        alloc_ready;
    logic [23:0] alloc_prd;
    logic [3:0]  rel_valid;
    logic [23:0] rel_preprd;
    logic        flush;
    logic [5:0]  free_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  av;
        logic [3:0]  rv;
        logic [23:0] rp;
        logic        fl;
        logic        er;
        logic [23:0] ep;
        logic [5:0]  ec;
    } vec_t;

    vec_t vecs [6];
    int   model [$];
    int   inflight [$];
    bit   seen [64];

    free_list dut (
        .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_prd(alloc_prd), .rel_valid(rel_valid), .rel_preprd(rel_preprd),
        .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tags(input int t3, input int t2, input int t1, input int t0);
        return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    endfunction

    task applyStimulus(input logic [3:0] av, input logic [3:0] rv, input logic [23:0] rp, input logic fl);
        @(negedge clk);
        alloc_valid = av;
        rel_valid   = rv;
        rel_preprd  = rp;
        flush       = fl;
        #1;
    endtask

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task checkPrd(input string name, input logic [3:0] mask, input logic [23:0] exp);
        for (int k = 0; k < 4; k++)
            if (mask[k])
                checkOutput($sformatf("%s slot%0d", name, k), 32'(alloc_prd[k*6 +: 6]), 32'(exp[k*6 +: 6]));
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task doReset();
        rst = 1'b1;
        alloc_valid = '0; rel_valid = '0; rel_preprd = '0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task allocCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(4'b1111, 4'b0000, '0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [3:0]  av, rv;
        logic [23:0] rp;
        int na, j, distinct;

        vecs[0] = '{4'b0000, 4'b0000, '0, 1'b0, 1'b1, '0, 6'd32};
        vecs[1] = '{4'b1111, 4'b0000, '0, 1'b0, 1'b1, tags(35, 34, 33, 32), 6'd28};
        vecs[2] = '{4'b1010, 4'b0000, '0, 1'b0, 1'b1, tags(37, 0, 36, 0), 6'd26};
        vecs[3] = '{4'b0100, 4'b0001, tags(0, 0, 0, 32), 1'b0, 1'b1, tags(0, 38, 0, 0), 6'd26};
        vecs[4] = '{4'b1111, 4'b0010, tags(0, 0, 33, 0), 1'b1, 1'b1, tags(42, 41, 40, 39), 6'd32};
        vecs[5] = '{4'b0001, 4'b0000, '0, 1'b0, 1'b1, tags(0, 0, 0, 34), 6'd31};

        doReset();
        checkOutput("reset count", 32'(free_count), 32);
        checkOutput("reset ready", 32'(alloc_ready), 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].av, vecs[i].rv, vecs[i].rp, vecs[i].fl);
            checkOutput($sformatf("vec%0d ready", i), 32'(alloc_ready), 32'(vecs[i].er));
            checkPrd($sformatf("vec%0d prd", i), vecs[i].av, vecs[i].ep);
            tick();
            checkOutput($sformatf("vec%0d count", i), 32'(free_count), 32'(vecs[i].ec));
        end

        // Sparse allocation straight out of reset.
        doReset();
        applyStimulus(4'b1010, 4'b0000, '0, 1'b0);
        checkPrd("sparse prd", 4'b1010, tags(33, 0, 32, 0));
        tick();
        checkOutput("sparse count", 32'(free_count), 30);
        checkOutput("sparse head", 32'(dut.head), 2);

        // Drain to empty, stall, then refill from commit.
        doReset();
        allocCycles(8);
        checkOutput("empty count", 32'(free_count), 0);
        applyStimulus(4'b0001, 4'b0000, '0, 1'b0);
        checkOutput("empty ready", 32'(alloc_ready), 0);
        tick();
        checkOutput("empty head frozen", 32'(dut.head), 32);
        checkOutput("empty count hold", 32'(free_count), 0);
        applyStimulus(4'b0000, 4'b0011, tags(0, 0, 6, 5), 1'b0);
        tick();
        checkOutput("refill count", 32'(free_count), 2);
        applyStimulus(4'b0011, 4'b0000, '0, 1'b0);
        checkOutput("refill ready", 32'(alloc_ready), 1);
        checkPrd("refill prd", 4'b0011, tags(0, 0, 6, 5));
        tick();
        checkOutput("refill drained", 32'(free_count), 0);

        // Flush in the same cycle as two commits.
        doReset();
        allocCycles(2);
        checkOutput("flush pre head", 32'(dut.head), 8);
        applyStimulus(4'b0000, 4'b0011, tags(0, 0, 9, 7), 1'b1);
        tick();
        checkOutput("flush head", 32'(dut.head), 2);
        checkOutput("flush tail", 32'(dut.tail), 34);
        checkOutput("flush count", 32'(free_count), 32);
        applyStimulus(4'b0001, 4'b0000, '0, 1'b0);
        checkPrd("flush prd", 4'b0001, tags(0, 0, 0, 34));
        tick();

        // Exact-fit allocation with a simultaneous four-wide release.
        doReset();
        allocCycles(7);
        applyStimulus(4'b0001, 4'b0000, '0, 1'b0);
        tick();
        checkOutput("fit pre count", 32'(free_count), 3);
        applyStimulus(4'b0111, 4'b1111, tags(35, 34, 33, 32), 1'b0);
        checkOutput("fit ready", 32'(alloc_ready), 1);
        checkPrd("fit prd", 4'b0111, tags(0, 63, 62, 61));
        tick();
        checkOutput("fit count", 32'(free_count), 4);
        applyStimulus(4'b1111, 4'b0000, '0, 1'b0);
        checkPrd("fit wrap prd", 4'b1111, tags(35, 34, 33, 32));
        tick();

        // Reset while traffic is in flight.
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, tags(1, 2, 3, 4), 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("midreset count", 32'(free_count), 32);
        applyStimulus(4'b0001, 4'b0000, '0, 1'b0);
        checkPrd("midreset prd", 4'b0001, tags(0, 0, 0, 32));

        // Random legal traffic against a queue model of the free tags.
        doReset();
        model.delete();
        inflight.delete();
        for (int t = 32; t < 64; t++) model.push_back(t);
        for (int c = 0; c < 100; c++) begin
            av = 4'($urandom_range(0, 15));
            rv = '0;
            rp = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1 && inflight.size() > 0) begin
                    j = $urandom_range(0, inflight.size() - 1);
                    rv[k] = 1'b1;
                    rp[k*6 +: 6] = 6'(inflight[j]);
                    inflight.delete(j);
                end
            end
            applyStimulus(av, rv, rp, 1'b0);
            na = $countones(av);
            checkOutput("rnd ready", 32'(alloc_ready), 32'(model.size() >= na));
            if (model.size() >= na) begin
                for (int k = 0; k < 4; k++) begin
                    if (av[k]) begin
                        checkOutput("rnd prd", 32'(alloc_prd[k*6 +: 6]), 32'(model[0]));
                        inflight.push_back(model[0]);
                        void'(model.pop_front());
                    end
                end
            end
            for (int k = 0; k < 4; k++)
                if (rv[k]) model.push_back(int'(rp[k*6 +: 6]));
            tick();
            checkOutput("rnd count", 32'(free_count), 32'(model.size()));
        end

        for (int g = 0; g < 40 && inflight.size() > 0; g++) begin
            rv = '0;
            rp = '0;
            for (int k = 0; k < 4; k++) begin
                if (inflight.size() > 0) begin
                    rv[k] = 1'b1;
                    rp[k*6 +: 6] = 6'(inflight[0]);
                    model.push_back(inflight[0]);
                    void'(inflight.pop_front());
                end
            end
            applyStimulus(4'b0000, rv, rp, 1'b0);
            tick();
        end
        checkOutput("drain count", 32'(free_count), 32);

        for (int t = 0; t < 64; t++) seen[t] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b1111, 4'b0000, '0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                checkOutput("final prd", 32'(alloc_prd[k*6 +: 6]), 32'(model[0]));
                void'(model.pop_front());
                seen[alloc_prd[k*6 +: 6]] = 1'b1;
            end
            tick();
        end
        distinct = 0;
        for (int t = 32; t < 64; t++) if (seen[t]) distinct++;
        checkOutput("final distinct tags", 32'(distinct), 32);
        checkOutput("final count", 32'(free_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
